pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Merges per-stage stall requests

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests, sequences exception flushes.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_EN.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_stall_req,
  input  logic             mem_stall_req,
  input  logic             bus_busy,
  input  logic [31:0]      exception_type,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned REC_W  = 4;
  localparam logic [31:0] ERET   = 32'h0000000E;
  localparam logic [5:0]  ALL_ST = 6'b111111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [31:0]      cap_tgt, cap_tgt_n;
  logic [REC_W-1:0] rec_cnt, rec_cnt_n;
  logic             flush_q;
  logic [5:0]       merged;
  logic [31:0]      tgt;
  logic             exc;

  // Priority stall merge: the deepest requesting stage wins
  always_comb begin
    merged = 6'b000000;
    if (mem_stall_req)     merged = 6'b011111;
    else if (ex_stall_req) merged = 6'b001111;
    else if (id_stall_req) merged = 6'b000111;
    else if (if_stall_req) merged = 6'b000011;
  end

  assign tgt = (exception_type == ERET) ? cp0_epc : EXC_VECTOR;
  assign exc = (exception_type != 32'd0);

  // Next-state and same-cycle outputs
  always_comb begin
    stall     = 6'b000000;
    flush     = 1'b0;
    new_pc    = 32'd0;
    state_n   = state;
    cap_tgt_n = cap_tgt;
    rec_cnt_n = rec_cnt;
    if (!rst) begin
      case (state)
        RUN: begin
          stall = merged;
          if (exc) begin
            // A busy bus, or a flush in the previous cycle, parks the exception in DRAIN
            if (bus_busy || flush_q) begin
              stall     = ALL_ST;
              cap_tgt_n = tgt;
              state_n   = DRAIN;
            end else begin
              stall  = 6'b000000;
              flush  = 1'b1;
              new_pc = tgt;
              if (RECOVER_CYCLES == 0) begin
                state_n = RUN;
              end else begin
                state_n   = RECOVER;
                rec_cnt_n = REC_W'(RECOVER_CYCLES);
              end
            end
          end
        end
        DRAIN: begin
          if (bus_busy) begin
            stall = ALL_ST;
          end else begin
            flush  = 1'b1;
            new_pc = cap_tgt;
            if (RECOVER_CYCLES == 0) begin
              state_n = RUN;
            end else begin
              state_n   = RECOVER;
              rec_cnt_n = REC_W'(RECOVER_CYCLES);
            end
          end
        end
        RECOVER: begin
          stall = merged;
          if (rec_cnt <= REC_W'(1)) begin
            state_n   = RUN;
            rec_cnt_n = '0;
          end else begin
            rec_cnt_n = rec_cnt - REC_W'(1);
          end
        end
        default: begin
          state_n   = RUN;
          rec_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cap_tgt <= 32'd0;
      rec_cnt <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_n;
      cap_tgt <= cap_tgt_n;
      rec_cnt <= rec_cnt_n;
      flush_q <= flush;
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of cycles with any stall bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((stall != 6'b000000) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
